// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO (divide enabled by MULDIV_DIV_EN)
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic             mf_req,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  state_t state, state_n;
  logic [4:0] cnt;
  logic [2*WIDTH-1:0] acc, step, res;
  logic [WIDTH-1:0] b, abs_a, abs_b;
  logic [WIDTH:0] msum;
  logic sa, sb, neg_q, go;
  assign sa = ~md_op[0] & rdata1[WIDTH-1];
  assign sb = ~md_op[0] & rdata2[WIDTH-1];
  assign abs_a = sa ? -rdata1 : rdata1;
  assign abs_b = sb ? -rdata2 : rdata2;
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
  assign busy = state != IDLE;
  assign stall = busy & (md_start | mf_req | mt_hi | mt_lo);
`ifdef MULDIV_DIV_EN
  logic div_op, neg_r;
  logic [WIDTH:0] dsub;
  logic [WIDTH-1:0] quo, rem;
  assign go = md_start;
  // restoring step: trial-subtract the divisor from the shifted partial remainder
  assign dsub = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
  assign step = div_op ? (dsub[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                       : {msum, acc[WIDTH-1:1]};
  // a zero divisor leaves rem = |a|, so restoring the dividend sign yields the raw rdata1
  assign quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res = div_op ? {rem, quo} : (neg_q ? -acc : acc);
  // latch op kind and dividend sign at acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) {div_op, neg_r} <= '0;
    else if (state == IDLE && go) {div_op, neg_r} <= {md_op[1], sa};
`else
  assign go = md_start & ~md_op[1];
  assign step = {msum, acc[WIDTH-1:1]};
  assign res = neg_q ? -acc : acc;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: IDLE -> CALC for WIDTH iterations -> FIX -> IDLE
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (go ? CALC : IDLE) :
              state == CALC ? (cnt == LAST ? FIX : CALC) : IDLE;
  end
  // datapath, HI/LO and done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      b <= '0;
      neg_q <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && go) begin
        acc <= {{WIDTH{1'b0}}, abs_a};
        b <= abs_b;
        cnt <= '0;
        neg_q <= (sa ^ sb) & (|rdata2);
      end else if (state == IDLE) begin
        if (mt_hi) hi <= rdata1;
        if (mt_lo) lo <= rdata1;
      end else if (state == CALC) begin
        acc <= step;
        cnt <= cnt + 5'd1;
      end else begin
        {hi, lo} <= res;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv
module tb_ex_muldiv;
  logic clk = 1'b0, rst = 1'b1, md_start = 1'b0, mf_req = 1'b0, mt_hi = 1'b0, mt_lo = 1'b0;
  logic [1:0] md_op = 2'b00;
  logic [31:0] rdata1 = '0, rdata2 = '0;
  logic [31:0] hi, lo;
  logic busy, done, stall;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;
  int tests = 0, fails = 0;
  logic seen;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .rdata1(rdata1), .rdata2(rdata2), .mf_req(mf_req), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    else begin
      exp_v = sb_q.pop_front();
      chk(tag, {hi, lo}, exp_v);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] bb,
                       input logic [63:0] want, input logic with_mf);
    int n;
    @(negedge clk);
    md_op = op; rdata1 = a; rdata2 = bb; md_start = 1'b1;
    sb_q.push_back(want);
    @(negedge clk);
    md_start = 1'b0; mf_req = with_mf;
    n = 0;
    while (busy && n < 40) begin
      if (with_mf) chk({tag, "_stall_busy"}, 64'(stall), 64'd1);
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (with_mf) chk({tag, "_stall_free"}, 64'(stall), 64'd0);
    pop_chk({tag, "_result"});
    mf_req = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    // MTLO / MTHI in idle
    @(negedge clk); mt_lo = 1'b1; rdata1 = 32'h1234;
    @(negedge clk); mt_lo = 1'b0;
    chk("mtlo", 64'(lo), 64'h1234);
    mt_hi = 1'b1; rdata1 = 32'h55;
    @(negedge clk); mt_hi = 1'b0;
    chk("mthi", {hi, lo}, {32'h55, 32'h1234});
    // reset mid-CALC aborts and clears
    md_op = 2'b00; rdata1 = 32'd3; rdata2 = 32'd5; md_start = 1'b1;
    @(negedge clk); md_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    // multiplies
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    do_op("multu_mix", 2'b01, 32'h1234_5678, 32'h0000_1000, 64'h0000_0123_4567_8000, 1'b0);
    // MTHI during busy is held off
    @(negedge clk); mt_hi = 1'b1; rdata1 = 32'h77;
    @(negedge clk); mt_hi = 1'b0;
    chk("mthi_pre", 64'(hi), 64'h77);
    md_op = 2'b00; rdata1 = 32'd2; rdata2 = 32'd3; md_start = 1'b1;
    sb_q.push_back({32'd0, 32'd6});
    @(negedge clk); md_start = 1'b0; mt_hi = 1'b1; rdata1 = 32'hDEAD;
    for (int i = 0; i < 40 && busy; i++) begin
      chk("mthi_busy_stall", 64'(stall), 64'd1);
      chk("mthi_busy_hold", 64'(hi), 64'h77);
      @(negedge clk);
    end
    mt_hi = 1'b0;
    chk("mthi_busy_done", 64'(done), 64'd1);
    pop_chk("mthi_busy_result");
`ifdef MULDIV_DIV_EN
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b0);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    do_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 1'b0);
    do_op("div_pos_neg", 2'b10, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 1'b0);
`else
    exp_v = {hi, lo};
    @(negedge clk); md_op = 2'b10; rdata1 = 32'hFFFF_FFF9; rdata2 = 32'd2; md_start = 1'b1; mf_req = 1'b1;
    seen = 1'b0;
    repeat (38) begin
      @(negedge clk);
      md_start = 1'b0;
      if (busy | done | stall) seen = 1'b1;
    end
    mf_req = 1'b0;
    chk("nodiv_quiet", 64'(seen), 64'd0);
    chk("nodiv_hilo", {hi, lo}, {32'd0, 32'd6});
    do_op("nodiv_then_mult", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
`endif
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
